// File: rtl/int_divider_iter_if.sv
// Operand/result bundle between the free-running divider and its surroundings.
// Protocol: no valid/ready; dvd/dvs are level inputs sampled once per operation,
// and rdy is a one-cycle strobe marking the cycle in which quo has just changed.
interface int_divider_iter_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic             rdy;
  logic             dbg_run;

  modport master (
    output dvd,
    output dvs,
    input  quo,
    input  rdy,
    input  dbg_run
  );

  modport slave (
    input  dvd,
    input  dvs,
    output quo,
    output rdy,
    output dbg_run
  );
endinterface

// File: rtl/int_divider_iter.sv
// Free-running unsigned restoring divider: one quotient bit per clock, MSB first,
// result published with a one-cycle rdy strobe every WIDTH+1 cycles.
module int_divider_iter #(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst,
  int_divider_iter_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic             rdy_q;

  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] acc_d;

  // acc_q starts as the dividend; each step shifts its MSB into the remainder
  // and the new quotient bit into its LSB, so after WIDTH steps it is the quotient.
  // The stored remainder is always below the divisor, so WIDTH bits hold it.
  always_comb begin
    rem_sh = {rem_q, acc_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_d  = ge ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
    acc_d  = {acc_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          acc_q   <= bus.dvd;
          dvs_q   <= bus.dvs;
          rem_q   <= '0;
          cnt_q   <= CW'(WIDTH - 1);
          rdy_q   <= 1'b0;
          state_q <= RUN;
        end
        RUN: begin
          rem_q <= rem_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            quo_q   <= acc_d;
            rdy_q   <= 1'b1;
            state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus.quo     = quo_q;
  assign bus.rdy     = rdy_q;
  assign bus.dbg_run = (state_q == RUN);
endmodule

// File: tb/tb_int_divider_iter.sv
// Directed bench for int_divider_iter: reset, periodic strobes, operand changes,
// boundary quotients, divide by zero, asynchronous reset mid-operation.
module tb_int_divider_iter;
  localparam int W = 12;
  localparam int PERIOD = W + 1;

  logic clk;
  logic rst;

  int n_total;
  int n_bad;

  logic [W-1:0] last_q;
  logic [W-1:0] exp_q[$];

  int_divider_iter_if #(.WIDTH(W)) bus ();

  int_divider_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step n edges; rdy must stay low and quo must hold until the n-th edge,
  // where rdy pulses and quo takes the next expected quotient.
  task automatic expect_pulse(input int n);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i < n) begin
        check_eq("rdy_idle", 32'(bus.rdy), 32'd0);
        check_eq("quo_hold", 32'(bus.quo), 32'(last_q));
      end else begin
        check_eq("rdy_pulse", 32'(bus.rdy), 32'd1);
        check_eq("quo", 32'(bus.quo), 32'(e));
      end
    end
    last_q = e;
  endtask

  // Called right after a strobe: the next edge is LOAD, so new operands apply now.
  task automatic apply_vec(input int a, input int b, input int e);
    bus.dvd = W'(a);
    bus.dvs = W'(b);
    exp_q.push_back(W'(e));
    expect_pulse(PERIOD);
  endtask

  initial begin
    int a;
    int b;
    int e;
    n_total = 0;
    n_bad   = 0;
    last_q  = '0;
    rst     = 1'b1;
    bus.dvd = 12'd255;
    bus.dvs = 12'd3;

    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rst_quo", 32'(bus.quo), 32'd0);
      check_eq("rst_rdy", 32'(bus.rdy), 32'd0);
      check_eq("rst_state", 32'(bus.dbg_run), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // first result on the 13th edge, then strictly periodic
    exp_q.push_back(12'd85);
    expect_pulse(PERIOD);

    // dvs changes after LOAD: in-flight operation unaffected
    tick();
    check_eq("rdy_load", 32'(bus.rdy), 32'd0);
    check_eq("run_after_load", 32'(bus.dbg_run), 32'd1);
    bus.dvs = 12'd5;
    exp_q.push_back(12'd85);
    expect_pulse(PERIOD - 1);
    exp_q.push_back(12'd51);
    expect_pulse(PERIOD);

    apply_vec(4095, 1, 4095);
    apply_vec(4095, 4095, 1);
    apply_vec(100, 200, 0);
    apply_vec(0, 7, 0);
    apply_vec(1000, 7, 142);
    apply_vec(1234, 0, 4095);

    // asynchronous reset between edges, halfway through RUN
    bus.dvd = 12'd1000;
    bus.dvs = 12'd7;
    for (int i = 0; i < 7; i++) tick();
    #3;
    rst = 1'b1;
    #1;
    check_eq("midrst_quo", 32'(bus.quo), 32'd0);
    check_eq("midrst_rdy", 32'(bus.rdy), 32'd0);
    check_eq("midrst_state", 32'(bus.dbg_run), 32'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    last_q = '0;
    exp_q.push_back(12'd142);
    expect_pulse(PERIOD);

    for (int k = 0; k < 1000; k++) begin
      a = int'($urandom_range(0, 4095));
      if (k % 4 == 0) b = int'($urandom_range(0, 3));
      else            b = int'($urandom_range(0, 4095));
      e = (b == 0) ? 4095 : a / b;
      apply_vec(a, b, e);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
